// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encodings,
// I/O-space decode bit and the suppressed-write test used on the debug path.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_e;

  localparam int IO_SPACE_BIT = 7;

  // A debug write into I/O space is dropped unless the build enables it.
  function automatic logic io_write_blocked(input logic        we,
                                            input logic [31:0] addr,
                                            input logic        io_en);
    return we & addr[IO_SPACE_BIT] & ~io_en;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: CPU MEM stage has fixed
// priority, the debug/loader port gets a forced one-cycle grant after STARVE_LIMIT waits.
//
// state | meaning
// IDLE  | port owned by CPU, no debug request pending
// WAIT  | debug request blocked by CPU traffic, starvation counter running
// GRANT | port owned by debug for one cycle, CPU stalled if it is requesting
// ACK   | debug access complete (dbg_ack high), port back to CPU
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4,
  parameter int DBG_IO_EN    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic             IO_EN = (DBG_IO_EN != 0);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             grant;
  logic             io_blocked;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (dbg_req) begin
          if (cpu_req) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_W'(1);
          end else begin
            state_nxt = ST_GRANT;
          end
        end
      end
      ST_WAIT: begin
        if (!dbg_req) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (!cpu_req || cnt >= LIMIT) begin
          state_nxt = ST_GRANT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_GRANT: begin
        state_nxt = ST_ACK;
        cnt_nxt   = '0;
      end
      ST_ACK: begin
        // A still-high dbg_req here is stale; a new request is picked up from IDLE.
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign grant      = (state == ST_GRANT);
  assign io_blocked = io_write_blocked(dbg_we, dbg_addr, IO_EN);

  // mem_we is decoded from state and gated by reset so no write lands once reset rises.
  always_comb begin
    mem_addr   = cpu_addr;
    mem_datain = cpu_wdata;
    mem_we     = cpu_we & cpu_req;
    if (grant) begin
      mem_addr   = dbg_addr;
      mem_datain = dbg_wdata;
      mem_we     = dbg_we & ~io_blocked;
    end
    if (reset) mem_we = 1'b0;
  end

  assign cpu_rdata = mem_dataout;
  assign cpu_stall = grant & cpu_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dbg_ack   <= 1'b0;
      dbg_err   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= grant;
      dbg_err <= grant & io_blocked;
      if (grant) dbg_rdata <= mem_dataout;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 64-word memory model behind the port.
module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_ack, dbg_err;
  logic [31:0] mem_addr, mem_datain, mem_dataout;
  logic        mem_we;
  logic        mem_load;
  logic [31:0] mem [0:63];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dmem_port_arbiter #(.STARVE_LIMIT(8), .CNT_W(4), .DBG_IO_EN(0)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_we(mem_we),
    .mem_dataout(mem_dataout)
  );

  // Word i initialised to 0x1000_0000 + i; word 32 (0x80) is out_port0.
  assign mem_dataout = mem[mem_addr[7:2]];
  always @(posedge clock) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_datain;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h0BAD_0BAD;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got %b want 0", dbg_ack); end
    total++; if (dbg_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", dbg_err); end
    total++; if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", dbg_rdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cpu_passthrough();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    #1;
    total++; if (mem_addr !== 32'h20) begin bad++; $display("FAIL cpu_addr_mux got %h want 20", mem_addr); end
    total++; if (cpu_rdata !== 32'h1000_0008) begin bad++; $display("FAIL cpu_load got %h want 10000008", cpu_rdata); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL cpu_load_we got %b want 0", mem_we); end
    cpu_we = 1'b1; cpu_wdata = 32'hCAFE_0001;
    #1;
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL cpu_store_we got %b want 1", mem_we); end
    total++; if (mem_datain !== 32'hCAFE_0001) begin bad++; $display("FAIL cpu_store_data got %h want cafe0001", mem_datain); end
    tick();
    cpu_we = 1'b0;
    #1;
    total++; if (cpu_rdata !== 32'hCAFE_0001) begin bad++; $display("FAIL cpu_readback got %h want cafe0001", cpu_rdata); end
    cpu_req = 1'b0;
  endtask

  task automatic test_dbg_read();
    cpu_req = 1'b0; cpu_addr = 32'h3C;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    #1;
    total++; if (mem_addr !== 32'h3C) begin bad++; $display("FAIL rd_idle_owner got %h want 3c", mem_addr); end
    tick();
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL rd_grant_addr got %h want 10", mem_addr); end
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL rd_grant_ack got %b want 0", dbg_ack); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rd_grant_stall got %b want 0", cpu_stall); end
    tick();
    total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL rd_ack got %b want 1", dbg_ack); end
    total++; if (dbg_rdata !== 32'h1000_0004) begin bad++; $display("FAIL rd_data got %h want 10000004", dbg_rdata); end
    total++; if (dbg_err !== 1'b0) begin bad++; $display("FAIL rd_err got %b want 0", dbg_err); end
    total++; if (mem_addr !== 32'h3C) begin bad++; $display("FAIL rd_ack_owner got %h want 3c", mem_addr); end
    dbg_req = 1'b0;
    tick();
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL rd_ack_pulse got %b want 0", dbg_ack); end
    total++; if (dbg_rdata !== 32'h1000_0004) begin bad++; $display("FAIL rd_data_hold got %h want 10000004", dbg_rdata); end
  endtask

  task automatic test_starvation();
    int  waits = 0;
    bit  seen  = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h14;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h14; dbg_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (cpu_stall === 1'b1) seen = 1'b1;
      else waits++;
    end
    total++; if (!seen) begin bad++; $display("FAIL starve_timeout got no stall within 20 cycles want stall"); end
    total++; if (waits != 8) begin bad++; $display("FAIL starve_waits got %0d want 8", waits); end
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h14) begin
      bad++; $display("FAIL starve_grant_port got we=%b addr=%h want we=1 addr=14", mem_we, mem_addr);
    end
    tick();
    total++; if (dbg_ack !== 1'b1) begin bad++; $display("FAIL starve_ack got %b want 1", dbg_ack); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL starve_stall_len got %b want 0", cpu_stall); end
    total++; if (dbg_rdata !== 32'h1000_0005) begin bad++; $display("FAIL starve_rdata got %h want 10000005", dbg_rdata); end
    dbg_req = 1'b0; dbg_we = 1'b0;
    #1;
    total++; if (cpu_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL starve_cpu_load got %h want deadbeef", cpu_rdata); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_io_write();
    cpu_req = 1'b0; cpu_addr = 32'h3C;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h80; dbg_wdata = 32'h5;
    tick();
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL io_we got %b want 0", mem_we); end
    tick();
    total++; if (dbg_ack !== 1'b1 || dbg_err !== 1'b1) begin
      bad++; $display("FAIL io_ack_err got ack=%b err=%b want ack=1 err=1", dbg_ack, dbg_err);
    end
    total++; if (mem[32] !== 32'h1000_0020) begin bad++; $display("FAIL io_port_unchanged got %h want 10000020", mem[32]); end
    dbg_req = 1'b0; dbg_we = 1'b0;
    tick();
    total++; if (dbg_err !== 1'b0) begin bad++; $display("FAIL io_err_pulse got %b want 0", dbg_err); end
  endtask

  task automatic test_cpu_drop();
    int stalls = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3C;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h18;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_stall !== 1'b0) stalls++;
    end
    total++; if (mem_addr !== 32'h3C) begin bad++; $display("FAIL drop_wait_owner got %h want 3c", mem_addr); end
    cpu_req = 1'b0;
    tick();
    if (cpu_stall !== 1'b0) stalls++;
    total++; if (mem_addr !== 32'h18) begin bad++; $display("FAIL drop_grant_addr got %h want 18", mem_addr); end
    tick();
    total++; if (stalls != 0) begin bad++; $display("FAIL drop_stall_count got %0d want 0", stalls); end
    total++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h1000_0006) begin
      bad++; $display("FAIL drop_ack got ack=%b data=%h want ack=1 data=10000006", dbg_ack, dbg_rdata);
    end
    dbg_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_grant();
    cpu_req = 1'b0; cpu_addr = 32'h3C;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h1C; dbg_wdata = 32'h1234_5678;
    tick();
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rg_grant_we got %b want 1", mem_we); end
    reset = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rg_we_kill got %b want 0", mem_we); end
    tick();
    total++; if (dbg_ack !== 1'b0 || dbg_rdata !== 32'h0) begin
      bad++; $display("FAIL rg_no_ack got ack=%b data=%h want ack=0 data=0", dbg_ack, dbg_rdata);
    end
    total++; if (mem[7] !== 32'h1000_0007) begin bad++; $display("FAIL rg_mem_unchanged got %h want 10000007", mem[7]); end
    dbg_req = 1'b0; dbg_we = 1'b0;
    reset = 1'b0;
    tick();
    total++; if (dbg_ack !== 1'b0 || mem_addr !== 32'h3C) begin
      bad++; $display("FAIL rg_idle got ack=%b addr=%h want ack=0 addr=3c", dbg_ack, mem_addr);
    end
  endtask

  task automatic test_abort_back_to_back();
    int acks = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3C;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
    tick();
    tick();
    dbg_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dbg_ack !== 1'b0 || cpu_stall !== 1'b0) acks++;
    end
    total++; if (acks != 0) begin bad++; $display("FAIL abort_no_ack got %0d want 0", acks); end
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_addr = 32'h10;
    tick();
    tick();
    total++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h1000_0004) begin
      bad++; $display("FAIL b2b_first got ack=%b data=%h want ack=1 data=10000004", dbg_ack, dbg_rdata);
    end
    dbg_addr = 32'h14;
    tick();
    total++; if (dbg_ack !== 1'b0 || mem_addr !== 32'h3C) begin
      bad++; $display("FAIL b2b_idle_gap got ack=%b addr=%h want ack=0 addr=3c", dbg_ack, mem_addr);
    end
    tick();
    total++; if (mem_addr !== 32'h14) begin bad++; $display("FAIL b2b_grant_addr got %h want 14", mem_addr); end
    tick();
    total++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL b2b_second got ack=%b data=%h want ack=1 data=deadbeef", dbg_ack, dbg_rdata);
    end
    dbg_req = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; mem_load = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick();
    tick();
    mem_load = 1'b0;
    test_reset();
    test_cpu_passthrough();
    test_dbg_read();
    test_starvation();
    test_io_write();
    test_cpu_drop();
    test_reset_in_grant();
    test_abort_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
